// File: rtl/imc_core.sv
// imc_core: computes a*b + c*d with two parallel shift-add multiplier lanes.
// Optional sticky protocol-error detection is built when IMC_PROTO_ERR_EN is defined.
module imc_core #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           imc_start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  output logic           imc_ready,
  output logic [2*W:0]   result,
  output logic           res_valid,
  input  logic           res_accept,
  output logic           proto_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic [2*W:0]            result_reg;
  logic                    load, step;
  logic [1:0][W-1:0]       mcand_in, mplier_in;
  logic [1:0][2*W-1:0]     prod;

  assign load      = (state_reg == IDLE) && imc_start;
  assign step      = (state_reg == MUL);
  assign mcand_in  = {c, a};
  assign mplier_in = {d, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (imc_start) state_next = MUL;
      MUL:     if (cnt_reg == CNT_LAST) state_next = ADD;
      ADD:     state_next = DONE;
      DONE:    if (res_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_reg <= '0;
    else if (load) cnt_reg <= '0;
    else if (step) cnt_reg <= cnt_reg + 1'b1;
  end

  // Lane 0 computes a*b, lane 1 computes c*d; both consume one multiplier bit per MUL cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [2*W-1:0] mcand_reg;
      logic [2*W-1:0] acc_reg;
      logic [W-1:0]   mplier_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mcand_reg  <= '0;
          mplier_reg <= '0;
          acc_reg    <= '0;
        end else if (load) begin
          mcand_reg  <= {{W{1'b0}}, mcand_in[gi]};
          mplier_reg <= mplier_in[gi];
          acc_reg    <= '0;
        end else if (step) begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
        end
      end

      assign prod[gi] = acc_reg;
    end
  endgenerate

  // Sum is widened by one bit so the carry of two maximal products survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 result_reg <= '0;
    else if (state_reg == ADD)  result_reg <= {1'b0, prod[0]} + {1'b0, prod[1]};
  end

  assign result    = result_reg;
  assign imc_ready = (state_reg == IDLE);
  assign res_valid = (state_reg == DONE);

`ifdef IMC_PROTO_ERR_EN
  logic proto_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              proto_err_reg <= 1'b0;
    else if (imc_start && state_reg != IDLE) proto_err_reg <= 1'b1;
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 1'b0;
`endif

endmodule
